// File: rtl/led_alarm_pkg.sv
// Shared definitions for the car-alarm LED output stage: state encoding and counter widths.
package led_alarm_pkg;

    localparam int ST_W    = 2;
    localparam int HB_BITS = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_EXIT  = 2'd1,
        ST_ARMED = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

endpackage

// File: rtl/led_alarm_mux_tick_prescaler.sv
// Free-running prescaler: one-cycle tick when the counter is all-ones, then it wraps to zero.
module tick_prescaler #(
    parameter int TICKBITS = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    logic [TICKBITS-1:0] cnt_q;
    logic [TICKBITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + TICKBITS'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = &cnt_q;

endmodule

// File: rtl/led_alarm_mux.sv
// LED output stage: bouncer pass-through when disarmed, otherwise exit/heartbeat/alarm patterns
// from the arm/alarm state machine, plus siren enable. All outputs lag the FSM by one cycle.
module led_alarm_mux
    import led_alarm_pkg::*;
#(
    parameter int NLEDS       = 8,
    parameter int TICKBITS    = 20,
    parameter int ARM_TICKS   = 16,
    parameter int ALARM_TICKS = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NLEDS-1:0] i_bounce,
    input  logic             i_arm,
    input  logic             i_disarm,
    input  logic             i_sensor,
    output logic [NLEDS-1:0] o_led,
    output logic [ST_W-1:0]  o_state,
    output logic             o_siren
);

    localparam int MAX_TICKS = (ARM_TICKS > ALARM_TICKS) ? ARM_TICKS : ALARM_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_TICKS - 1);
    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_TICKS - 1);

    logic tick;

    tick_prescaler #(
        .TICKBITS(TICKBITS)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .o_tick (tick)
    );

    state_e               state_q,     state_d;
    logic [CNT_W-1:0]     tick_cnt_q,  tick_cnt_d;
    logic [HB_BITS-1:0]   hb_cnt_q,    hb_cnt_d;
    logic                 phase_q,     phase_d;
    logic [NLEDS-1:0]     led_q,       led_d;
    logic [ST_W-1:0]      state_out_q, state_out_d;
    logic                 siren_q,     siren_d;

    // Every state entry clears both counters; only EXIT/ALARM entries also force phase high.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        hb_cnt_d   = hb_cnt_q;
        phase_d    = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (i_arm && !i_disarm) begin
                    state_d    = ST_EXIT;
                    tick_cnt_d = '0;
                    hb_cnt_d   = '0;
                    phase_d    = 1'b1;
                end
            end
            ST_EXIT: begin
                if (i_disarm) begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                    hb_cnt_d   = '0;
                end else if (tick) begin
                    if (tick_cnt_q == ARM_LAST) begin
                        state_d    = ST_ARMED;
                        tick_cnt_d = '0;
                        hb_cnt_d   = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                        phase_d    = ~phase_q;
                    end
                end
            end
            ST_ARMED: begin
                if (i_disarm) begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                    hb_cnt_d   = '0;
                end else if (i_sensor) begin
                    state_d    = ST_ALARM;
                    tick_cnt_d = '0;
                    hb_cnt_d   = '0;
                    phase_d    = 1'b1;
                end else if (tick) begin
                    hb_cnt_d = hb_cnt_q + HB_BITS'(1);
                end
            end
            ST_ALARM: begin
                if (i_disarm) begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                    hb_cnt_d   = '0;
                end else if (tick) begin
                    if (tick_cnt_q == ALARM_LAST && !i_sensor) begin
                        state_d    = ST_ARMED;
                        tick_cnt_d = '0;
                        hb_cnt_d   = '0;
                    end else begin
                        // Retrigger restarts the hold window but keeps flashing in rhythm.
                        tick_cnt_d = (tick_cnt_q == ALARM_LAST) ? '0 : tick_cnt_q + CNT_W'(1);
                        phase_d    = ~phase_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        led_d = '0;
        case (state_q)
            ST_IDLE:  led_d    = i_bounce;
            ST_EXIT:  led_d[0] = phase_q;
            ST_ARMED: led_d[0] = (hb_cnt_q == '0);
            ST_ALARM: led_d    = {NLEDS{phase_q}};
            default:  led_d    = '0;
        endcase
        state_out_d = state_q;
        siren_d     = (state_q == ST_ALARM);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            hb_cnt_q    <= '0;
            phase_q     <= 1'b0;
            led_q       <= '0;
            state_out_q <= ST_IDLE;
            siren_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            hb_cnt_q    <= hb_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            state_out_q <= state_out_d;
            siren_q     <= siren_d;
        end
    end

    assign o_led   = led_q;
    assign o_state = state_out_q;
    assign o_siren = siren_q;

endmodule

// File: tb/tb_led_alarm_mux.sv
// Directed bench for led_alarm_mux with a 4-clock tick, 3-tick exit delay and 4-tick alarm hold.
module tb_led_alarm_mux;

    localparam int NLEDS = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NLEDS-1:0] bounce;
    logic             arm;
    logic             disarm;
    logic             sensor;
    logic [NLEDS-1:0] led;
    logic [1:0]       state;
    logic             siren;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    led_alarm_mux #(
        .NLEDS      (NLEDS),
        .TICKBITS   (2),
        .ARM_TICKS  (3),
        .ALARM_TICKS(4)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_bounce(bounce),
        .i_arm   (arm),
        .i_disarm(disarm),
        .i_sensor(sensor),
        .o_led   (led),
        .o_state (state),
        .o_siren (siren)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_led,
                              input logic [1:0] e_state, input logic e_siren);
        check_eq({tag, ".led"},   32'(led),   32'(e_led));
        check_eq({tag, ".state"}, 32'(state), 32'(e_state));
        check_eq({tag, ".siren"}, 32'(siren), 32'(e_siren));
    endtask

    // Edge numbers in comments count rising edges after the last reset edge (edge 0).
    initial begin
        reset  = 1'b1;
        bounce = '0;
        arm    = 1'b0;
        disarm = 1'b0;
        sensor = 1'b0;
        step();
        step();
        check_outs("reset", 8'h00, 2'd0, 1'b0);

        // Pass-through
        reset  = 1'b0;
        bounce = 8'h10;
        step();                                   // e1
        check_outs("pass_10", 8'h10, 2'd0, 1'b0);
        bounce = 8'h20;
        step();                                   // e2
        check_outs("pass_20", 8'h20, 2'd0, 1'b0);

        // Exit delay, ticks at e4/e8/e12
        arm = 1'b1;
        step();                                   // e3: FSM enters EXIT
        arm = 1'b0;
        check_outs("arm_lat", 8'h20, 2'd0, 1'b0);
        step();                                   // e4
        check_outs("exit_in", 8'h01, 2'd1, 1'b0);
        sensor = 1'b1;
        step();                                   // e5
        check_outs("exit_ph0", 8'h00, 2'd1, 1'b0);
        repeat (4) step();                        // e9
        check_outs("exit_ph1", 8'h01, 2'd1, 1'b0);
        sensor = 1'b0;
        repeat (3) step();                        // e12: third tick
        check_outs("exit_last", 8'h01, 2'd1, 1'b0);
        step();                                   // e13
        check_outs("armed_in", 8'h01, 2'd2, 1'b0);

        // Heartbeat over 16 ticks: lit only while hb_cnt==0
        for (int e = 14; e <= 76; e++) begin
            step();
            check_outs("hb", (((e - 13) / 4) % 8 == 0) ? 8'h01 : 8'h00, 2'd2, 1'b0);
        end

        // Alarm with retrigger, ticks at e80/e84/e88/e92
        sensor = 1'b1;
        step();                                   // e77
        check_outs("alarm_lat", 8'h01, 2'd2, 1'b0);
        step();                                   // e78
        check_outs("alarm_in", 8'hFF, 2'd3, 1'b1);
        repeat (2) step();                        // e80
        check_outs("alarm_t1", 8'hFF, 2'd3, 1'b1);
        step();                                   // e81
        check_outs("alarm_ph0", 8'h00, 2'd3, 1'b1);
        repeat (4) step();                        // e85
        check_outs("alarm_ph1", 8'hFF, 2'd3, 1'b1);
        repeat (4) step();                        // e89
        check_outs("alarm_ph0b", 8'h00, 2'd3, 1'b1);
        repeat (4) step();                        // e93: after 4th tick
        check_outs("retrigger", 8'hFF, 2'd3, 1'b1);
        sensor = 1'b0;
        repeat (14) step();                       // e107
        check_outs("hold_end", 8'h00, 2'd3, 1'b1);
        step();                                   // e108: 4th tick of new window
        check_outs("hold_last", 8'h00, 2'd3, 1'b1);
        step();                                   // e109
        check_outs("rearmed", 8'h01, 2'd2, 1'b0);

        // Disarm beats sensor
        sensor = 1'b1;
        step();                                   // e110
        step();                                   // e111
        check_outs("alarm2", 8'hFF, 2'd3, 1'b1);
        bounce = 8'h5A;
        disarm = 1'b1;
        step();                                   // e112
        disarm = 1'b0;
        sensor = 1'b0;
        step();                                   // e113
        check_outs("disarm", 8'h5A, 2'd0, 1'b0);

        // Arm + disarm together in IDLE
        arm    = 1'b1;
        disarm = 1'b1;
        step();                                   // e114
        arm    = 1'b0;
        disarm = 1'b0;
        step();                                   // e115
        check_outs("arm_disarm", 8'h5A, 2'd0, 1'b0);
        bounce = 8'hA5;
        step();                                   // e116
        check_outs("idle_hold", 8'hA5, 2'd0, 1'b0);

        // Back into ALARM, then reset mid-alarm
        arm = 1'b1;
        step();                                   // e117
        arm = 1'b0;
        repeat (11) step();                       // e128: third exit tick
        sensor = 1'b1;
        step();                                   // e129
        step();                                   // e130
        check_outs("alarm3", 8'hFF, 2'd3, 1'b1);
        reset = 1'b1;
        step();                                   // e131 = new edge 0
        reset  = 1'b0;
        bounce = 8'hC3;
        check_outs("mid_reset", 8'h00, 2'd0, 1'b0);
        step();                                   // r1, sensor ignored in IDLE
        check_outs("post_reset", 8'hC3, 2'd0, 1'b0);
        sensor = 1'b0;
        arm    = 1'b1;
        step();                                   // r2: EXIT
        arm = 1'b0;
        step();                                   // r3
        check_outs("re_exit", 8'h01, 2'd1, 1'b0);
        step();                                   // r4: first tick after reset
        check_outs("re_tick", 8'h01, 2'd1, 1'b0);
        step();                                   // r5
        check_outs("re_ph0", 8'h00, 2'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
